// File: rtl/acquire.sv
// ---------------------------------------------------------------------------
// acquire -- sample-capture engine for the logic analyser.
//
// Once grant_acq is seen high, the block copies one ADC sample per enabled
// cycle into the capture RAM at sequential addresses. After RAM_SIZE writes it
// raises done_acq and holds it until grant_acq is withdrawn. It never
// restarts on its own.
//
// Optional feature macro: ACQ_HALF_RATE_EN
//   defined   : only every second ACQ cycle is enabled, so wr_en pulses once
//               every two clocks. The first ACQ cycle is enabled.
//   undefined : every ACQ cycle is enabled, one sample per clock.
//
// Ports
//   clk          system clock; all state changes on its rising edge
//   rst          asynchronous, active-low reset
//   grant_acq    level grant from the upstream arbiter
//   adc_data     ADC sample, captured on enabled rising edges
//   done_acq     high once RAM_SIZE samples are written, until grant drops
//   wr_addr      RAM write address (low ADDR_W bits of the sample counter)
//   wr_data      RAM write data
//   wr_en        RAM write strobe
//   dbg_state_o  current FSM state, for debug and assertions
//
// RAM handshake: wr_addr, wr_data and wr_en are all registered and valid in
// the same cycle. The RAM takes the write on the next rising edge. There is
// no back-pressure, so each cycle with wr_en high is exactly one write.
// ---------------------------------------------------------------------------
module acquire #(
  parameter int RAM_SIZE = 1024,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              grant_acq,
  input  logic [DATA_W-1:0] adc_data,
  output logic              done_acq,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en,
  output logic [1:0]        dbg_state_o
);

  // One extra counter bit, so the count can reach RAM_SIZE without wrapping.
  localparam int CNT_W = $clog2(RAM_SIZE) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RAM_SIZE - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_en_q, wr_en_d;
  logic              done_q, done_d;
  logic              sample_en;

`ifdef ACQ_HALF_RATE_EN
  // phase_q is 0 on enabled ACQ cycles. It is cleared on entry to ACQ, so
  // the first ACQ cycle is always enabled.
  logic phase_q, phase_d;
  assign sample_en = ~phase_q;
`else
  assign sample_en = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_en_d = 1'b0;
    done_d  = done_q;
`ifdef ACQ_HALF_RATE_EN
    phase_d = phase_q;
`endif
    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (grant_acq) begin
          state_d = S_ACQ;
          cnt_d   = '0;
          addr_d  = '0;
`ifdef ACQ_HALF_RATE_EN
          phase_d = 1'b0;
`endif
        end
      end
      S_ACQ: begin
        if (!grant_acq) begin
          // Abort: leave address and data as they are, and never flag done.
          state_d = S_IDLE;
          done_d  = 1'b0;
        end else begin
`ifdef ACQ_HALF_RATE_EN
          phase_d = ~phase_q;
`endif
          if (sample_en) begin
            data_d  = adc_data;
            wr_en_d = 1'b1;
            // The address wraps naturally because only the low bits are kept.
            addr_d  = ADDR_W'(cnt_q);
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (!grant_acq) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end else begin
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef ACQ_HALF_RATE_EN
      phase_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_en_q <= wr_en_d;
      done_q  <= done_d;
`ifdef ACQ_HALF_RATE_EN
      phase_q <= phase_d;
`endif
    end
  end

  assign wr_addr     = addr_q;
  assign wr_data     = data_q;
  assign wr_en       = wr_en_q;
  assign done_acq    = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_acquire.sv
// ---------------------------------------------------------------------------
// tb_acquire -- self-checking bench for acquire.
//
// Three instances share the clock, the reset and adc_data, and each has its
// own grant:
//   sel 0 : RAM_SIZE=16    (basic capture, handshake, abort/reset)
//   sel 1 : RAM_SIZE=1536  (address wrap with ADDR_W=10)
//   sel 2 : RAM_SIZE=8     (short capture; alternate-cycle strobes when
//                           ACQ_HALF_RATE_EN is defined)
//
// Reference model: the run_capture task predicts the output of each clock
// cycle from the cycle number alone, counted from the edge that first sees
// the grant. That edge clears the address. Write k lands at cycle
// 1 + k*STEP with data equal to the sample driven before that edge. done
// follows one cycle after the last write.
// ---------------------------------------------------------------------------
module tb_acquire;

`ifdef ACQ_HALF_RATE_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic [DW-1:0] adc_data;
  logic          grant_s, grant_w, grant_h;
  logic          done_s, done_w, done_h;
  logic [AW-1:0] addr_s, addr_w, addr_h;
  logic [DW-1:0] data_s, data_w, data_h;
  logic          en_s, en_w, en_h;
  logic [1:0]    st_s, st_w, st_h;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-instance model of the held address and data.
  int            m_addr [3];
  logic [DW-1:0] m_data [3];

  acquire #(.RAM_SIZE(16), .ADDR_W(AW), .DATA_W(DW)) dut_s (
    .clk(clk), .rst(rst), .grant_acq(grant_s), .adc_data(adc_data),
    .done_acq(done_s), .wr_addr(addr_s), .wr_data(data_s), .wr_en(en_s),
    .dbg_state_o(st_s));

  acquire #(.RAM_SIZE(1536), .ADDR_W(AW), .DATA_W(DW)) dut_w (
    .clk(clk), .rst(rst), .grant_acq(grant_w), .adc_data(adc_data),
    .done_acq(done_w), .wr_addr(addr_w), .wr_data(data_w), .wr_en(en_w),
    .dbg_state_o(st_w));

  acquire #(.RAM_SIZE(8), .ADDR_W(AW), .DATA_W(DW)) dut_h (
    .clk(clk), .rst(rst), .grant_acq(grant_h), .adc_data(adc_data),
    .done_acq(done_h), .wr_addr(addr_h), .wr_data(data_h), .wr_en(en_h),
    .dbg_state_o(st_h));

  // ---- clock ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view of one instance's outputs: {wr_en, done_acq, wr_addr, wr_data}.
  function automatic logic [AW+DW+1:0] obs(input int sel);
    case (sel)
      0:       obs = {en_s, done_s, addr_s, data_s};
      1:       obs = {en_w, done_w, addr_w, data_w};
      default: obs = {en_h, done_h, addr_h, data_h};
    endcase
  endfunction

  task automatic set_grant(input int sel, input logic v);
    case (sel)
      0:       grant_s = v;
      1:       grant_w = v;
      default: grant_h = v;
    endcase
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      m_addr[i] = 0;
      m_data[i] = '0;
    end
  endtask

  // Full acquisition on one instance. The grant is held for `hold` cycles
  // after done, then dropped. Every cycle is checked.
  task automatic run_capture(input string name, input int sel, input int n,
                             input int hold);
    int total;
    int idx;
    logic          x_en, x_done;
    logic [AW+DW+1:0] exp_v, got_v;
    total = 2 + (n - 1) * STEP + hold;
    set_grant(sel, 1'b1);
    for (int c = 0; c < total; c++) begin
      adc_data = DW'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      x_en = 1'b0;
      x_done = 1'b0;
      if (c == 0) begin
        m_addr[sel] = 0;
      end else begin
        idx = c - 1;
        if ((idx % STEP) == 0 && (idx / STEP) < n) begin
          x_en = 1'b1;
          m_addr[sel] = (idx / STEP) % (1 << AW);
          m_data[sel] = adc_data;
        end
        if (idx >= (n - 1) * STEP + 1) x_done = 1'b1;
      end
      exp_v = {x_en, x_done, AW'(m_addr[sel]), m_data[sel]};
      got_v = obs(sel);
      n_cmp++;
      if (got_v !== exp_v) begin
        n_bad++;
        $display("FAIL %s cycle=%0d got=%h exp=%h", name, c, got_v, exp_v);
      end
      @(negedge clk);
    end
    set_grant(sel, 1'b0);
    @(posedge clk);
    #1;
    exp_v = {1'b0, 1'b0, AW'(m_addr[sel]), m_data[sel]};
    got_v = obs(sel);
    n_cmp++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s_release got=%h exp=%h", name, got_v, exp_v);
    end
    @(negedge clk);
  endtask

  // Reset held low with grant high: every output must stay zero.
  task automatic test_reset();
    rst = 1'b0;
    grant_s = 1'b1;
    grant_w = 1'b1;
    grant_h = 1'b1;
    clear_model();
    for (int c = 0; c < 6; c++) begin
      adc_data = DW'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
        n_cmp++;
        if (obs(s) !== '0) begin
          n_bad++;
          $display("FAIL reset sel=%0d cycle=%0d got=%h exp=0", s, c, obs(s));
        end
      end
      @(negedge clk);
    end
    grant_s = 1'b0;
    grant_w = 1'b0;
    grant_h = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    run_capture("basic", 0, 16, 1);
  endtask

  // Grant is held well past done, then dropped and raised again.
  // The second run must start over from address 0.
  task automatic test_handshake();
    run_capture("hs_hold", 0, 16, 20);
    repeat (2) @(negedge clk);
    run_capture("hs_restart", 0, 16, 2);
  endtask

  task automatic test_wrap();
    run_capture("wrap", 1, 1536, 3);
  endtask

  task automatic test_short();
    run_capture("short", 2, 8, 4);
  endtask

  // Grant is dropped right after the write to address 5. Then a new capture
  // starts, and reset is pulsed after the write to address 7.
  task automatic test_abort_reset();
    logic [AW+DW+1:0] exp_v, got_v;
    set_grant(0, 1'b1);
    for (int c = 0; c <= 1 + 5 * STEP; c++) begin
      adc_data = DW'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      if (c == 1 + 5 * STEP) begin
        m_addr[0] = 5;
        m_data[0] = adc_data;
        exp_v = {1'b1, 1'b0, AW'(5), adc_data};
        got_v = obs(0);
        n_cmp++;
        if (got_v !== exp_v) begin
          n_bad++;
          $display("FAIL abort_addr5 got=%h exp=%h", got_v, exp_v);
        end
      end
      @(negedge clk);
    end
    set_grant(0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      adc_data = DW'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      exp_v = {1'b0, 1'b0, AW'(m_addr[0]), m_data[0]};
      got_v = obs(0);
      n_cmp++;
      if (got_v !== exp_v) begin
        n_bad++;
        $display("FAIL abort_idle cycle=%0d got=%h exp=%h", c, got_v, exp_v);
      end
      @(negedge clk);
    end

    set_grant(0, 1'b1);
    for (int c = 0; c <= 1 + 7 * STEP; c++) begin
      adc_data = DW'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      if (c == 1 + 7 * STEP) begin
        exp_v = {1'b1, 1'b0, AW'(7), adc_data};
        got_v = obs(0);
        n_cmp++;
        if (got_v !== exp_v) begin
          n_bad++;
          $display("FAIL rerun_addr7 got=%h exp=%h", got_v, exp_v);
        end
      end
      @(negedge clk);
    end
    // Assert reset in the middle of the low phase. The outputs must clear
    // before the next rising edge.
    #2;
    rst = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      n_cmp++;
      if (obs(s) !== '0) begin
        n_bad++;
        $display("FAIL async_reset sel=%0d got=%h exp=0", s, obs(s));
      end
    end
    clear_model();
    set_grant(0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (obs(0) !== '0) begin
      n_bad++;
      $display("FAIL post_reset_idle got=%h exp=0", obs(0));
    end
  endtask

  initial begin
    adc_data = '0;
    rst = 1'b0;
    grant_s = 1'b0;
    grant_w = 1'b0;
    grant_h = 1'b0;
    clear_model();
    @(negedge clk);
    test_reset();
    test_basic();
    test_handshake();
    test_abort_reset();
    test_short();
    test_wrap();
    test_basic();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
